// File: rtl/ahb_arbiter_slave_if.sv
// ahb_arbiter_slave_if: per-slave request/transfer inputs and grant/owner outputs of one slave-port arbiter
interface ahb_arbiter_slave_if #(
    parameter int SLAVE_X_MASTER_NUM = 3,
    parameter int MST_IDX_W          = (SLAVE_X_MASTER_NUM > 1) ? $clog2(SLAVE_X_MASTER_NUM) : 1
);
    logic [SLAVE_X_MASTER_NUM-1:0]      hreq;
    logic [SLAVE_X_MASTER_NUM-1:0][1:0] htrans_m;
    logic [SLAVE_X_MASTER_NUM-1:0][2:0] hburst_m;
    logic                               hready;
    logic [SLAVE_X_MASTER_NUM-1:0]      hgrant;
    logic                               hsel_slv;
    logic [MST_IDX_W-1:0]               hmaster_sel;
    logic [SLAVE_X_MASTER_NUM-1:0]      data_owner;
    modport slave (
        input  hreq, htrans_m, hburst_m, hready,
        output hgrant, hsel_slv, hmaster_sel, data_owner
    );
    modport master (
        output hreq, htrans_m, hburst_m, hready,
        input  hgrant, hsel_slv, hmaster_sel, data_owner
    );
endinterface

// File: rtl/ahb_arbiter_slave.sv
// ahb_arbiter_slave: per-slave AHB arbiter with burst locking; round-robin by default,
// fixed lowest-index priority when AHB_ARB_FIXED_PRIO_EN is defined.
module ahb_arbiter_slave #(
    parameter int SLAVE_X_MASTER_NUM = 3,
    parameter int MST_IDX_W          = (SLAVE_X_MASTER_NUM > 1) ? $clog2(SLAVE_X_MASTER_NUM) : 1
) (
    input logic                hclk,
    input logic                hreset,
    ahb_arbiter_slave_if.slave bus
);
    localparam int N = SLAVE_X_MASTER_NUM;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_e;
    logic [N-1:0]         grant_q, grant_d, owner_q, owner_d;
    logic [4:0]           beat_cnt_q, beat_cnt_d;
    logic                 incr_lock_q, incr_lock_d;
    logic [MST_IDX_W-1:0] sel, win;
    htrans_e              own_trans;
    logic [2:0]           own_burst;
    logic                 locked, arb_found;
`ifdef AHB_ARB_FIXED_PRIO_EN
    logic [MST_IDX_W-1:0] rr_q;
    assign rr_q = '0;
`else
    logic [MST_IDX_W-1:0] rr_q, rr_d;
    always_comb rr_d = (bus.hready && !locked && arb_found) ?
                       (win == MST_IDX_W'(N - 1) ? '0 : win + 1'b1) : rr_q;
    always_ff @(posedge hclk or posedge hreset)
        if (hreset) rr_q <= '0;
        else        rr_q <= rr_d;
`endif
    always_comb begin
        sel       = '0;
        own_trans = IDLE;
        own_burst = '0;
        for (int m = 0; m < N; m++)
            if (grant_q[m]) begin
                sel       = MST_IDX_W'(m);
                own_trans = htrans_e'(bus.htrans_m[m]);
                own_burst = bus.hburst_m[m];
            end
    end
    // An INCR owner only stays locked while it keeps requesting this slave
    assign locked = (beat_cnt_q != 5'd0) || (incr_lock_q && |(bus.hreq & grant_q));
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        incr_lock_d = incr_lock_q;
        if (bus.hready) begin
            if (own_trans == NONSEQ) begin
                incr_lock_d = (own_burst == 3'b001);
                beat_cnt_d  = own_burst[2:1] == 2'b11 ? 5'd15 :
                              own_burst[2:1] == 2'b10 ? 5'd7  :
                              own_burst[2:1] == 2'b01 ? 5'd3  : 5'd0;
            end else if (own_trans == SEQ) begin
                beat_cnt_d = beat_cnt_q != 5'd0 ? beat_cnt_q - 5'd1 : 5'd0;
            end else if (own_trans == IDLE) begin
                beat_cnt_d  = 5'd0;
                incr_lock_d = 1'b0;
            end
        end
    end
    always_comb begin
        arb_found = 1'b0;
        win       = '0;
        for (int i = 0; i < N; i++)
            if (!arb_found && bus.hreq[(int'(rr_q) + i) % N]) begin
                arb_found = 1'b1;
                win       = MST_IDX_W'((int'(rr_q) + i) % N);
            end
        grant_d = grant_q;
        if (bus.hready && !locked)
            grant_d = arb_found ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
        owner_d = bus.hready ? (own_trans[1] ? grant_q : '0) : owner_q;
    end
    always_ff @(posedge hclk or posedge hreset)
        if (hreset) begin
            grant_q     <= '0;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            incr_lock_q <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            incr_lock_q <= incr_lock_d;
        end
    assign bus.hgrant      = grant_q;
    assign bus.hsel_slv    = |grant_q;
    assign bus.hmaster_sel = sel;
    assign bus.data_owner  = owner_q;
endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// tb_ahb_arbiter_slave: directed scenarios for the slave-port arbiter (3 masters)
module tb_ahb_arbiter_slave;
    localparam int N = 3;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    ahb_arbiter_slave_if #(.SLAVE_X_MASTER_NUM(N)) bus ();
    ahb_arbiter_slave #(.SLAVE_X_MASTER_NUM(N)) dut (.hclk(clk), .hreset(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.htrans_m = '0;
        bus.hburst_m = '0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.hreq   = '0;
        bus.hready = 1'b1;
        idle_all();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.hreq   = 3'b111;
        bus.hready = 1'b1;
        idle_all();
        tick();
        tick();
        total++; if (bus.hgrant !== 3'b000) begin bad++; $display("FAIL reset_hgrant got=%b exp=000", bus.hgrant); end
        total++; if (bus.hsel_slv !== 1'b0) begin bad++; $display("FAIL reset_hsel got=%b exp=0", bus.hsel_slv); end
        total++; if (bus.hmaster_sel !== 2'd0) begin bad++; $display("FAIL reset_hmaster_sel got=%0d exp=0", bus.hmaster_sel); end
        total++; if (bus.data_owner !== 3'b000) begin bad++; $display("FAIL reset_data_owner got=%b exp=000", bus.data_owner); end
        rst = 1'b0;
        tick();
        total++; if (bus.hgrant !== 3'b001) begin bad++; $display("FAIL reset_release_grant got=%b exp=001", bus.hgrant); end
        total++; if (bus.hsel_slv !== 1'b1) begin bad++; $display("FAIL reset_release_hsel got=%b exp=1", bus.hsel_slv); end
    endtask

    task automatic test_round_robin();
`ifdef AHB_ARB_FIXED_PRIO_EN
        logic [2:0] eg [4] = '{3'b001, 3'b001, 3'b001, 3'b001};
        logic [2:0] ed [4] = '{3'b000, 3'b001, 3'b001, 3'b001};
        logic [1:0] es [4] = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        logic [2:0] eg [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [2:0] ed [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
        logic [1:0] es [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
`endif
        do_reset();
        bus.hreq     = 3'b111;
        bus.htrans_m = {3{2'b10}};
        bus.hburst_m = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.hgrant !== eg[i]) begin bad++; $display("FAIL rr_grant step=%0d got=%b exp=%b", i, bus.hgrant, eg[i]); end
            total++; if (bus.data_owner !== ed[i]) begin bad++; $display("FAIL rr_data_owner step=%0d got=%b exp=%b", i, bus.data_owner, ed[i]); end
            total++; if (bus.hmaster_sel !== es[i]) begin bad++; $display("FAIL rr_hmaster_sel step=%0d got=%0d exp=%0d", i, bus.hmaster_sel, es[i]); end
        end
        idle_all();
    endtask

    task automatic test_incr4_lock();
        do_reset();
        bus.hreq = 3'b001;
        tick();
        bus.htrans_m[0] = 2'b10;
        bus.hburst_m[0] = 3'b011;
        tick();
        total++; if (bus.hgrant !== 3'b001 || bus.data_owner !== 3'b001 || dut.beat_cnt_q !== 5'd3) begin
            bad++; $display("FAIL incr4_first grant=%b owner=%b cnt=%0d exp=001/001/3", bus.hgrant, bus.data_owner, dut.beat_cnt_q);
        end
        bus.hreq        = 3'b110;
        bus.htrans_m[0] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.hgrant !== 3'b001 || bus.data_owner !== 3'b001 || dut.beat_cnt_q !== 5'(2 - i)) begin
                bad++; $display("FAIL incr4_beat=%0d grant=%b owner=%b cnt=%0d exp=001/001/%0d", i + 2, bus.hgrant, bus.data_owner, dut.beat_cnt_q, 2 - i);
            end
        end
        bus.htrans_m[0] = 2'b00;
        tick();
        total++; if (bus.hgrant !== 3'b010 || bus.data_owner !== 3'b000 || bus.hmaster_sel !== 2'd1) begin
            bad++; $display("FAIL incr4_handover grant=%b owner=%b sel=%0d exp=010/000/1", bus.hgrant, bus.data_owner, bus.hmaster_sel);
        end
    endtask

    task automatic test_wait_states();
        logic [1:0] tr [11] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
        logic       rd [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0] ec [11] = '{5'd6, 5'd6, 5'd6, 5'd6, 5'd5, 5'd4, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        logic [2:0] ed [11] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010};
        do_reset();
        bus.hreq = 3'b010;
        tick();
        bus.htrans_m[1] = 2'b10;
        bus.hburst_m[1] = 3'b100;
        tick();
        total++; if (bus.hgrant !== 3'b010 || dut.beat_cnt_q !== 5'd7) begin
            bad++; $display("FAIL wrap8_first grant=%b cnt=%0d exp=010/7", bus.hgrant, dut.beat_cnt_q);
        end
        bus.hreq = 3'b011;
        for (int i = 0; i < 11; i++) begin
            bus.htrans_m[1] = tr[i];
            bus.hready      = rd[i];
            tick();
            total++; if (bus.hgrant !== 3'b010 || dut.beat_cnt_q !== ec[i] || bus.data_owner !== ed[i]) begin
                bad++; $display("FAIL wrap8_step=%0d grant=%b cnt=%0d owner=%b exp=010/%0d/%b", i, bus.hgrant, dut.beat_cnt_q, bus.data_owner, ec[i], ed[i]);
            end
        end
        bus.htrans_m[1] = 2'b00;
        tick();
        total++; if (bus.hgrant !== 3'b001) begin bad++; $display("FAIL wrap8_release got=%b exp=001", bus.hgrant); end
    endtask

    task automatic test_incr_release();
        do_reset();
        bus.hreq = 3'b100;
        tick();
        bus.htrans_m[2] = 2'b10;
        bus.hburst_m[2] = 3'b001;
        tick();
        total++; if (bus.hgrant !== 3'b100 || dut.incr_lock_q !== 1'b1) begin
            bad++; $display("FAIL incr_first grant=%b lock=%b exp=100/1", bus.hgrant, dut.incr_lock_q);
        end
        bus.hreq        = 3'b101;
        bus.htrans_m[2] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (bus.hgrant !== 3'b100 || bus.data_owner !== 3'b100) begin
                bad++; $display("FAIL incr_hold beat=%0d grant=%b owner=%b exp=100/100", i + 2, bus.hgrant, bus.data_owner);
            end
        end
        bus.hreq        = 3'b001;
        bus.htrans_m[2] = 2'b00;
        tick();
        total++; if (bus.hgrant !== 3'b001 || bus.data_owner !== 3'b000) begin
            bad++; $display("FAIL incr_release grant=%b owner=%b exp=001/000", bus.hgrant, bus.data_owner);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.hreq = 3'b001;
        tick();
        bus.htrans_m[0] = 2'b10;
        bus.hburst_m[0] = 3'b111;
        tick();
        bus.htrans_m[0] = 2'b11;
        tick();
        total++; if (dut.beat_cnt_q !== 5'd14 || bus.data_owner !== 3'b001) begin
            bad++; $display("FAIL incr16_beat2 cnt=%0d owner=%b exp=14/001", dut.beat_cnt_q, bus.data_owner);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.hgrant !== 3'b000 || bus.hsel_slv !== 1'b0) begin
            bad++; $display("FAIL async_grant grant=%b hsel=%b exp=000/0", bus.hgrant, bus.hsel_slv);
        end
        total++; if (bus.data_owner !== 3'b000 || dut.beat_cnt_q !== 5'd0) begin
            bad++; $display("FAIL async_state owner=%b cnt=%0d exp=000/0", bus.data_owner, dut.beat_cnt_q);
        end
        idle_all();
        bus.hreq = 3'b111;
        #1 rst = 1'b0;
        tick();
        total++; if (bus.hgrant !== 3'b001) begin bad++; $display("FAIL async_restart got=%b exp=001", bus.hgrant); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_incr4_lock();
        test_wait_states();
        test_incr_release();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
